// File: rtl/fetch_stage_pkg.sv
// Shared DLX constants for the instruction-fetch stage: widths, reset PC and bubble encoding.
package fetch_stage_pkg;

  localparam int          DLX_PC_WIDTH   = 32;
  localparam int          DLX_ADDR_WIDTH = 10;
  localparam int          DLX_DATA_WIDTH = 32;
  localparam logic [31:0] DLX_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DLX_NOP_INST   = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and a synchronous RAM (slave).
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = DLX_ADDR_WIDTH,
  parameter int DATA_WIDTH = DLX_DATA_WIDTH
);

  // Handshake: no ready; each cycle inst_mem_rd_en is high the slave must present
  // the word at inst_mem_addr on inst_mem_data after the next rising edge.
  logic                  inst_mem_rd_en;
  logic [ADDR_WIDTH-1:0] inst_mem_addr;
  logic [DATA_WIDTH-1:0] inst_mem_data;

  modport master (
    output inst_mem_rd_en,
    output inst_mem_addr,
    input  inst_mem_data
  );

  modport slave (
    input  inst_mem_rd_en,
    input  inst_mem_addr,
    output inst_mem_data
  );

endinterface

// File: rtl/fetch_stage_hold_buf.sv
// Stall hold buffer: captures the word returning for F2 when a stall freezes the stage
// and selects the F2 data source (held word or live memory output).
module fetch_hold_buf
  import fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DLX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  f2_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] f2_data_o
);

  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d;

  // Capture only once per stall: memory output is stale after the first stalled cycle.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    if (flush_i || !stall_i) begin
      hold_valid_d = 1'b0;
    end else if (f2_valid_i && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_inst_d  = mem_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_inst_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  assign f2_data_o = hold_valid_q ? hold_inst_q : mem_data_i;

endmodule

// File: rtl/fetch_stage.sv
// DLX instruction-fetch stage: PC, F1 address issue, F2 data return and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    PC_WIDTH   = DLX_PC_WIDTH,
  parameter int                    ADDR_WIDTH = DLX_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DLX_DATA_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = DLX_RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DLX_NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_rd_en,
  input  logic                  stall,
  input  logic                  general_flush,
  input  logic                  select_new_pc,
  input  logic [PC_WIDTH-1:0]   new_pc,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] if_id_inst,
  output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
  output logic                  if_id_valid
);

  logic                  fetch_en;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  f2_valid_q, f2_valid_d;
  logic [PC_WIDTH-1:0]   f2_pc_q, f2_pc_d;
  logic [DATA_WIDTH-1:0] f2_data;
  logic                  if_id_valid_q, if_id_valid_d;
  logic [DATA_WIDTH-1:0] if_id_inst_q, if_id_inst_d;
  logic [PC_WIDTH-1:0]   if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic                  unused_new_pc_lsb;

  assign fetch_en            = inst_rd_en & ~stall;
  assign imem.inst_mem_rd_en = fetch_en;
  assign imem.inst_mem_addr  = pc_q[ADDR_WIDTH+1:2];
  assign unused_new_pc_lsb   = ^new_pc[1:0];

  // A redirect loads the PC even while stalled so the target is not lost.
  always_comb begin
    pc_d = pc_q;
    if (select_new_pc) begin
      pc_d = {new_pc[PC_WIDTH-1:2], 2'b00};
    end else if (fetch_en) begin
      pc_d = pc_q + PC_WIDTH'(4);
    end
  end

  always_comb begin
    f2_valid_d = f2_valid_q;
    f2_pc_d    = f2_pc_q;
    if (general_flush) begin
      f2_valid_d = 1'b0;
    end else if (!stall) begin
      f2_valid_d = fetch_en;
      f2_pc_d    = pc_q;
    end
  end

  always_comb begin
    if_id_valid_d    = if_id_valid_q;
    if_id_inst_d     = if_id_inst_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if (general_flush) begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
    end else if (!stall) begin
      if_id_valid_d    = f2_valid_q;
      if_id_inst_d     = f2_valid_q ? f2_data : NOP_INST;
      if_id_pc_plus4_d = f2_pc_q + PC_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      f2_valid_q       <= 1'b0;
      f2_pc_q          <= '0;
      if_id_valid_q    <= 1'b0;
      if_id_inst_q     <= NOP_INST;
      if_id_pc_plus4_q <= '0;
    end else begin
      pc_q             <= pc_d;
      f2_valid_q       <= f2_valid_d;
      f2_pc_q          <= f2_pc_d;
      if_id_valid_q    <= if_id_valid_d;
      if_id_inst_q     <= if_id_inst_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
    end
  end

  fetch_hold_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall),
    .flush_i    (general_flush),
    .f2_valid_i (f2_valid_q),
    .mem_data_i (imem.inst_mem_data),
    .f2_data_o  (f2_data)
  );

  assign if_id_inst     = if_id_inst_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_valid    = if_id_valid_q;

endmodule
